alu32_vector_checker: RTL
=========================

Name: alu32_vector_checker

Overview:
Sequential stimulus driver and result checker for the 32-bit add/sub ALU. A writer port loads up to NUM_VEC test vectors (operands, op and expected flags). On start, the block drives each vector into the ALU, waits a settle time, samples the ALU outputs and compares them field by field. It accumulates pass/fail counts and first-failure info for board LEDs or the simulation harness.

Parameters:
NUM_VEC, 7, number of vector slots; must be ≤ 2**ADDR_W.
ADDR_W, 3, vector index width.
SETTLE_CYCLES, 1, cycles held between driving operands and sampling results; ≥ 1.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle pulse that begins a run; honoured only in IDLE or DONE.
vec_we  in  1  vector write strobe; ignored while busy=1.
vec_waddr  in  ADDR_W  slot index; writes with vec_waddr ≥ NUM_VEC are dropped.
vec_a, vec_b  in  32  operands (two's complement).
vec_sub_add  in  1  0 = add, 1 = sub.
vec_exp_result  in  32  expected result.
vec_exp_carry, vec_exp_zero, vec_exp_overflow  in  1 each  expected flags.
alu_a, alu_b  out  32  operands driven to the ALU; registered.
alu_sub_add  out  1  op driven to the ALU; registered.
alu_result  in  32  ALU result.
alu_carry, alu_zero, alu_overflow  in  1 each  ALU flags.
busy  out  1  high in DRIVE, SETTLE and CHECK.
done  out  1  high in DONE.
pass_cnt, fail_cnt  out  ADDR_W+1  vectors passed and failed in the current run.
first_fail_valid  out  1  at least one failure has occurred this run.
first_fail_idx  out  ADDR_W  slot of the first failure.
mismatch_mask  out  4  sticky OR of mismatching fields {result, carry, zero, overflow}, MSB = result.

Behaviour:
- Reset: state=IDLE; every output 0, including alu_a, alu_b and alu_sub_add. All slot valid bits cleared. Vector storage contents are not reset.
- Write: when vec_we=1, busy=0 and the address is in range, the slot is written and its valid bit set at the clock edge. A rewrite overwrites the slot.
- FSM states: IDLE, DRIVE, SETTLE, CHECK, DONE.
- IDLE/DONE + start: clear the counters, first_fail_* and mismatch_mask; idx=0; go to DRIVE.
- DRIVE, slot valid: register the slot onto alu_* and load settle counter = SETTLE_CYCLES; go to SETTLE.
- DRIVE, slot invalid: the slot is skipped (counted as neither pass nor fail). If it is the last slot go to DONE, else idx++ and stay in DRIVE.
- SETTLE: decrement the counter each cycle; on the cycle the counter reaches 1, go to CHECK. SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- CHECK: compare all four fields for exact equality.
  - All equal: pass_cnt++.
  - Otherwise: fail_cnt++ and OR the per-field mismatches into mismatch_mask. If first_fail_valid=0, set it and latch idx into first_fail_idx.
  - Then: if idx = NUM_VEC-1 go to DONE, else idx++ and go to DRIVE.
- Latency: each valid vector takes SETTLE_CYCLES+2 cycles; each invalid slot takes 1 cycle. With all slots valid, done rises NUM_VEC*(SETTLE_CYCLES+2)+1 cycles after the edge that samples start. With defaults this is 22 cycles.
- alu_* outputs hold their last driven value outside DRIVE.
- Results and done hold until the next start or rst.
- Simultaneous events:
  - start while busy is ignored.
  - start and vec_we in the same IDLE cycle: the write completes, and that slot is read in DRIVE with its new data.
  - rst mid-run aborts immediately to the reset state. Slots must be rewritten after reset, since valid bits are cleared.
- Counters cannot wrap: they are ADDR_W+1 bits wide and NUM_VEC ≤ 2**ADDR_W.

Optional Feature:
ALU32_CHK_STOP_ON_FAIL_EN
- Defined: a CHECK that finds a mismatch goes straight to DONE, after the counters, first_fail_* and mismatch_mask have updated. Remaining slots are not run.
- Undefined: every slot is always checked.

Test Plan:
- Write slots 0..6 with correct expectations, e.g. slot0 5+3 → result 0x00000008, flags 0; slot1 5−5 → result 0, zero=1. Pulse start → done at cycle 22, pass_cnt=7, fail_cnt=0, mismatch_mask=0.
- Slot2 0x7FFFFFFF+0x00000001, expected result 0x80000000 with overflow=1 but stored overflow=0 → fail_cnt=1, first_fail_idx=2, mismatch_mask=4'b0001.
- Write only slots 0 and 4 after reset, then start → pass_cnt=2; done at 1+(2×3)+5 = 12 cycles.
- Assert rst for one cycle during SETTLE of slot 3 → all outputs 0, state IDLE. A start with no rewrites yields done with pass_cnt=fail_cnt=0.
- Pulse start and vec_we to slot 1 while busy → no restart and no write; the final counts match the original run.
- With ALU32_CHK_STOP_ON_FAIL_EN and a bad expectation in slot 1 → done after slot 1, pass_cnt=1, fail_cnt=1, first_fail_idx=1.

Source files
------------

// File: rtl/alu32_vector_checker.sv
// Stimulus driver and result checker for the 32-bit add/sub ALU: replays stored vectors and scores the responses.
// Optional build macro ALU32_CHK_STOP_ON_FAIL_EN ends a run at the first mismatching vector.
`timescale 1ns/1ps
module alu32_vector_checker #(
    parameter int NUM_VEC       = 7,
    parameter int ADDR_W        = 3,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              vec_we,
    input  logic [ADDR_W-1:0] vec_waddr,
    input  logic [31:0]       vec_a,
    input  logic [31:0]       vec_b,
    input  logic              vec_sub_add,
    input  logic [31:0]       vec_exp_result,
    input  logic              vec_exp_carry,
    input  logic              vec_exp_zero,
    input  logic              vec_exp_overflow,
    output logic [31:0]       alu_a,
    output logic [31:0]       alu_b,
    output logic              alu_sub_add,
    input  logic [31:0]       alu_result,
    input  logic              alu_carry,
    input  logic              alu_zero,
    input  logic              alu_overflow,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   pass_cnt,
    output logic [ADDR_W:0]   fail_cnt,
    output logic              first_fail_valid,
    output logic [ADDR_W-1:0] first_fail_idx,
    output logic [3:0]        mismatch_mask
);

    localparam int CNT_W  = ADDR_W + 1;
    localparam int SCNT_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  NUM_VEC_W = CNT_W'(NUM_VEC);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_VEC - 1);
    localparam logic [SCNT_W-1:0] SETTLE_LD = SCNT_W'(SETTLE_CYCLES);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t              state_r;
    state_t              stateNext_s;
    logic [ADDR_W-1:0]   idx_r;
    logic [SCNT_W-1:0]   settleCnt_r;
    logic [NUM_VEC-1:0]  valid_r;

    logic [31:0]         memA_r     [0:NUM_VEC-1];
    logic [31:0]         memB_r     [0:NUM_VEC-1];
    logic                memSub_r   [0:NUM_VEC-1];
    logic [31:0]         memRes_r   [0:NUM_VEC-1];
    logic                memCarry_r [0:NUM_VEC-1];
    logic                memZero_r  [0:NUM_VEC-1];
    logic                memOvf_r   [0:NUM_VEC-1];

    logic [31:0]         aluA_r;
    logic [31:0]         aluB_r;
    logic                aluSub_r;
    logic                busy_r;
    logic                done_r;
    logic [CNT_W-1:0]    passCnt_r;
    logic [CNT_W-1:0]    failCnt_r;
    logic                ffValid_r;
    logic [ADDR_W-1:0]   ffIdx_r;
    logic [3:0]          mask_r;

    logic                vecWrite_s;
    logic                slotValid_s;
    logic                lastSlot_s;
    logic [3:0]          mismatch_s;
    logic                loadAlu_s;
    logic                clearRun_s;
    logic                recordPass_s;
    logic                recordFail_s;
    logic                idxInc_s;

    assign vecWrite_s  = vec_we && !busy_r && ({1'b0, vec_waddr} < NUM_VEC_W);
    assign slotValid_s = valid_r[idx_r];
    assign lastSlot_s  = (idx_r == LAST_IDX);
    assign mismatch_s  = {(alu_result   != memRes_r[idx_r]),
                          (alu_carry    != memCarry_r[idx_r]),
                          (alu_zero     != memZero_r[idx_r]),
                          (alu_overflow != memOvf_r[idx_r])};

    // Vector storage: payload is deliberately left unreset, only valid bits clear.
    always_ff @(posedge clk) begin
        if (vecWrite_s) begin
            memA_r[vec_waddr]     <= vec_a;
            memB_r[vec_waddr]     <= vec_b;
            memSub_r[vec_waddr]   <= vec_sub_add;
            memRes_r[vec_waddr]   <= vec_exp_result;
            memCarry_r[vec_waddr] <= vec_exp_carry;
            memZero_r[vec_waddr]  <= vec_exp_zero;
            memOvf_r[vec_waddr]   <= vec_exp_overflow;
        end
    end

    // Slot valid bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= {NUM_VEC{1'b0}};
        end else if (vecWrite_s) begin
            valid_r[vec_waddr] <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= stateNext_s;
        end
    end

    // FSM next-state and datapath strobes.
    always_comb begin
        stateNext_s  = state_r;
        loadAlu_s    = 1'b0;
        clearRun_s   = 1'b0;
        recordPass_s = 1'b0;
        recordFail_s = 1'b0;
        idxInc_s     = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    clearRun_s  = 1'b1;
                    stateNext_s = DRIVE;
                end else begin
                    stateNext_s = state_r;
                end
            end
            DRIVE: begin
                if (slotValid_s) begin
                    loadAlu_s   = 1'b1;
                    stateNext_s = SETTLE;
                end else if (lastSlot_s) begin
                    stateNext_s = DONE;
                end else begin
                    idxInc_s    = 1'b1;
                    stateNext_s = DRIVE;
                end
            end
            SETTLE: begin
                if (settleCnt_r == SCNT_W'(1)) begin
                    stateNext_s = CHECK;
                end else begin
                    stateNext_s = SETTLE;
                end
            end
            CHECK: begin
                if (mismatch_s != 4'b0000) begin
                    recordFail_s = 1'b1;
                end else begin
                    recordPass_s = 1'b1;
                end
`ifdef ALU32_CHK_STOP_ON_FAIL_EN
                if ((mismatch_s != 4'b0000) || lastSlot_s) begin
                    stateNext_s = DONE;
                end else begin
                    idxInc_s    = 1'b1;
                    stateNext_s = DRIVE;
                end
`else
                if (lastSlot_s) begin
                    stateNext_s = DONE;
                end else begin
                    idxInc_s    = 1'b1;
                    stateNext_s = DRIVE;
                end
`endif
            end
            default: begin
                stateNext_s = IDLE;
            end
        endcase
    end

    // Run datapath: slot index, settle timer, ALU drive and scoring.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r       <= {ADDR_W{1'b0}};
            settleCnt_r <= {SCNT_W{1'b0}};
            aluA_r      <= 32'h0000_0000;
            aluB_r      <= 32'h0000_0000;
            aluSub_r    <= 1'b0;
            passCnt_r   <= {CNT_W{1'b0}};
            failCnt_r   <= {CNT_W{1'b0}};
            ffValid_r   <= 1'b0;
            ffIdx_r     <= {ADDR_W{1'b0}};
            mask_r      <= 4'b0000;
        end else begin
            if (clearRun_s) begin
                idx_r     <= {ADDR_W{1'b0}};
                passCnt_r <= {CNT_W{1'b0}};
                failCnt_r <= {CNT_W{1'b0}};
                ffValid_r <= 1'b0;
                ffIdx_r   <= {ADDR_W{1'b0}};
                mask_r    <= 4'b0000;
            end else if (idxInc_s) begin
                idx_r <= idx_r + ADDR_W'(1);
            end
            if (loadAlu_s) begin
                aluA_r      <= memA_r[idx_r];
                aluB_r      <= memB_r[idx_r];
                aluSub_r    <= memSub_r[idx_r];
                settleCnt_r <= SETTLE_LD;
            end else if (state_r == SETTLE) begin
                settleCnt_r <= settleCnt_r - SCNT_W'(1);
            end
            if (recordPass_s) begin
                passCnt_r <= passCnt_r + CNT_W'(1);
            end
            if (recordFail_s) begin
                failCnt_r <= failCnt_r + CNT_W'(1);
                mask_r    <= mask_r | mismatch_s;
                if (!ffValid_r) begin
                    ffValid_r <= 1'b1;
                    ffIdx_r   <= idx_r;
                end
            end
        end
    end

    // Status flags; done waits one cycle in DONE so the final scores are already visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (stateNext_s == DRIVE) || (stateNext_s == SETTLE) || (stateNext_s == CHECK);
            done_r <= (state_r == DONE) && (stateNext_s == DONE);
        end
    end

    assign alu_a            = aluA_r;
    assign alu_b            = aluB_r;
    assign alu_sub_add      = aluSub_r;
    assign busy             = busy_r;
    assign done             = done_r;
    assign pass_cnt         = passCnt_r;
    assign fail_cnt         = failCnt_r;
    assign first_fail_valid = ffValid_r;
    assign first_fail_idx   = ffIdx_r;
    assign mismatch_mask    = mask_r;

endmodule
